fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
Frame scheduler that shares one fft_multimode core between two sample-stream requesters. It arbitrates whole frames round-robin and drives the core's valid_in/sop_in/x_re/x_im/np/inv for one frame at a time. It tracks in-flight frames in a tag FIFO, so each output frame returns to its owner with sop/eop and a requester tag. It sits between the front-end requesters and the core.

Parameters:
DW, 16, sample width of re/im
TAG_DEPTH, 4, maximum frames in flight inside the core (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  2  per-requester frame request (level)
req_np  in  4  {req1_np, req0_np}; 00=64, 01=128, 10=256, 11=512 points
req_inv  in  2  per-requester inverse-FFT select
gnt  out  2  one-hot grant, held for the whole issued frame
s_valid  in  2  per-requester sample valid
s_ready  out  2  per-requester sample accept (= gnt while in ISSUE)
s_re  in  2*DW  {re1, re0}
s_im  in  2*DW  {im1, im0}
fft_valid_in  out  1  to core valid_in
fft_sop_in  out  1  to core sop_in
fft_x_re  out  DW  to core x_re
fft_x_im  out  DW  to core x_im
fft_np  out  2  to core np
fft_inv  out  1  to core inv
fft_valid_out  in  1  from core valid_out
fft_sop_out  in  1  from core sop_out
fft_y_re  in  DW  from core y_re
fft_y_im  in  DW  from core y_im
m_valid  out  1  result valid
m_sop  out  1  first result of a frame
m_eop  out  1  last result of a frame
m_tag  out  1  owning requester of the current result
m_re  out  DW  result real part
m_im  out  DW  result imaginary part
busy  out  1  state != IDLE or frames in flight
underflow_err  out  1  sticky: granted requester missed a sample
sop_err  out  1  sticky: core sop_out arrived with no frame pending

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, FIFO empty, RR pointer favours req0, errors cleared. Asserting reset mid-frame aborts the frame immediately; nothing is resumed.
- N(np): 64/128/256/512. Sample counters are 9 bits.
- States: IDLE, DRAIN, ISSUE.
- IDLE: if any req and FIFO not full, pick the winner round-robin (the requester after the last granted has priority).
  - If FIFO empty, or winner {np,inv} equals current fft_np/fft_inv, go to ISSUE.
  - Otherwise latch the winner and go to DRAIN.
  - If the FIFO is full, no grant is issued.
- DRAIN: gnt stays 0. Go to ISSUE when the FIFO is empty and the last m_eop has been emitted. fft_np/fft_inv change only on the DRAIN→ISSUE or IDLE→ISSUE edge; they are never changed while the FIFO is non-empty.
- ISSUE: gnt[g]=1 and s_ready[g]=1 for exactly N consecutive cycles.
  - Every cycle fft_valid_in=1, registered one cycle after acceptance; the frame is always contiguous.
  - fft_sop_in=1 on sample 0 only.
  - If s_valid[g]=0 in a cycle, a zero sample is sent and underflow_err is set.
  - Push {g, np} into the FIFO at sample 0.
  - After sample N-1: gnt drops, RR pointer updates, state returns to IDLE. This leaves a minimum one-cycle bubble between frames.
- Changes on req, req_np or req_inv during ISSUE are ignored.
- Output path (1-cycle registered):
  - On fft_valid_out with FIFO non-empty: m_valid=1 and m_tag = head tag.
  - fft_sop_out resets the output counter and sets m_sop.
  - m_eop is asserted at output count N(head np)-1; the FIFO pops on that cycle.
  - A push and a pop in the same cycle are both honoured.
  - fft_valid_out while the FIFO is empty: m_valid stays 0 and the data is dropped. If fft_sop_out is also set, sop_err is set.
- busy = (state != IDLE) or FIFO non-empty.

Decomposition:
- Package fft_sched_pkg: np encodings, function np_len(np) returning N, state enum.
- One sub-module fft_tag_fifo: synchronous FIFO, width 3 ({tag, np}), depth TAG_DEPTH, outputs full/empty, same clk and rst_n.

Test Plan:
1. Only req0 active, np=00, inv=0, ramp 0..63; core model echoes input after 10 cycles → 64 contiguous fft_valid_in, fft_sop_in on the first only, gnt=01 for 64 cycles; m_tag=0, m_sop on result 0, m_eop on result 63; busy=0 afterwards.
2. req0 and req1 both active, np=01 → frame 0 then frame 1 (128 each), one idle cycle between; results come back tag 0 then tag 1; with the core stalled, the 5th grant is withheld until the FIFO pops (TAG_DEPTH=4).
3. req0 np=00 frame in flight, req1 np=11 inv=1 requests → state DRAIN, gnt=00; fft_np becomes 11 and fft_inv 1 only after m_eop of the req0 frame.
4. req0 drops s_valid at sample 10 of a 64-point frame → fft_x_re/fft_x_im=0 at position 10, frame still 64 contiguous, underflow_err=1 and stays 1.
5. fft_valid_out and fft_sop_out injected with no frame pending → sop_err=1, m_valid stays 0.
6. rst_n pulsed low at sample 30 of ISSUE → gnt, fft_valid_in, m_valid all 0 immediately; after release a new request starts cleanly with fft_sop_in on sample 0.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the FFT frame scheduler: np encodings, frame
// length lookup and the scheduler state enum.
package fft_sched_pkg;

  localparam logic [1:0] NP_64  = 2'b00;
  localparam logic [1:0] NP_128 = 2'b01;
  localparam logic [1:0] NP_256 = 2'b10;
  localparam logic [1:0] NP_512 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  function automatic logic [9:0] np_len(input logic [1:0] np);
    case (np)
      NP_64:   return 10'd64;
      NP_128:  return 10'd128;
      NP_256:  return 10'd256;
      default: return 10'd512;
    endcase
  endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// Synchronous FIFO of {tag, np} records for frames in flight inside the core.
// DEPTH must be a power of two >= 2; push and pop in one cycle are both honoured.
module fft_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Round-robin whole-frame scheduler sharing one fft_multimode core between two
// requesters; returns each result frame with sop/eop and its owner's tag.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int DW        = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [3:0]    req_np,
  input  logic [1:0]    req_inv,
  output logic [1:0]    gnt,
  input  logic [1:0]    s_valid,
  output logic [1:0]    s_ready,
  input  logic [2*DW-1:0] s_re,
  input  logic [2*DW-1:0] s_im,
  output logic          fft_valid_in,
  output logic          fft_sop_in,
  output logic [DW-1:0] fft_x_re,
  output logic [DW-1:0] fft_x_im,
  output logic [1:0]    fft_np,
  output logic          fft_inv,
  input  logic          fft_valid_out,
  input  logic          fft_sop_out,
  input  logic [DW-1:0] fft_y_re,
  input  logic [DW-1:0] fft_y_im,
  output logic          m_valid,
  output logic          m_sop,
  output logic          m_eop,
  output logic          m_tag,
  output logic [DW-1:0] m_re,
  output logic [DW-1:0] m_im,
  output logic          busy,
  output logic          underflow_err,
  output logic          sop_err,
  output logic [1:0]    dbg_state
);
  state_e     state, state_nxt;
  logic       cur_g, rr_last;
  logic [8:0] cnt, out_cnt, out_idx;
  logic       win_g, sel_g, lat_g;
  logic [1:0] win_np, sel_np, lat_np;
  logic       win_inv, sel_inv, lat_inv;
  logic       start_issue, start_drain, issue_done, cnt_last;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2:0] fifo_dout;
  logic       out_take, out_last;
  logic [DW-1:0] lane_re, lane_im;

  // rr_last is the last granted requester; the other one has priority.
  assign win_g   = rr_last ? ~req[0] : req[1];
  assign win_np  = win_g ? req_np[3:2] : req_np[1:0];
  assign win_inv = req_inv[win_g];
  assign sel_g   = (state == S_DRAIN) ? lat_g   : win_g;
  assign sel_np  = (state == S_DRAIN) ? lat_np  : win_np;
  assign sel_inv = (state == S_DRAIN) ? lat_inv : win_inv;

  assign cnt_last = ({1'b0, cnt} == np_len(fft_np) - 10'd1);
  assign lane_re  = cur_g ? s_re[2*DW-1:DW] : s_re[DW-1:0];
  assign lane_im  = cur_g ? s_im[2*DW-1:DW] : s_im[DW-1:0];

  assign gnt       = (state == S_ISSUE) ? (cur_g ? 2'b10 : 2'b01) : 2'b00;
  assign s_ready   = gnt;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign dbg_state = state;

  // valid/ready: a sample moves from requester g to the core on every cycle
  // with s_ready[g]=1; if s_valid[g]=0 then a zero sample is sent instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_issue = 1'b0;
    start_drain = 1'b0;
    issue_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if ((|req) && !fifo_full) begin
          if (fifo_empty || (win_np == fft_np && win_inv == fft_inv)) begin
            state_nxt   = S_ISSUE;
            start_issue = 1'b1;
          end else begin
            state_nxt   = S_DRAIN;
            start_drain = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_nxt   = S_ISSUE;
          start_issue = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cnt_last) begin
          state_nxt  = S_IDLE;
          issue_done = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_g <= 1'b0; rr_last <= 1'b1; cnt <= '0;
      lat_g <= 1'b0; lat_np <= '0; lat_inv <= 1'b0;
      fft_np <= '0; fft_inv <= 1'b0;
      fft_valid_in <= 1'b0; fft_sop_in <= 1'b0;
      fft_x_re <= '0; fft_x_im <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (start_issue) begin
        cur_g   <= sel_g;
        fft_np  <= sel_np;
        fft_inv <= sel_inv;
        cnt     <= '0;
      end else if (state == S_ISSUE) begin
        cnt <= cnt + 1'b1;
      end
      if (start_drain) begin
        lat_g <= win_g; lat_np <= win_np; lat_inv <= win_inv;
      end
      if (issue_done) rr_last <= cur_g;
      fft_valid_in <= (state == S_ISSUE);
      fft_sop_in   <= (state == S_ISSUE) && (cnt == 9'd0);
      fft_x_re     <= ((state == S_ISSUE) && s_valid[cur_g]) ? lane_re : '0;
      fft_x_im     <= ((state == S_ISSUE) && s_valid[cur_g]) ? lane_im : '0;
      if ((state == S_ISSUE) && !s_valid[cur_g]) underflow_err <= 1'b1;
    end
  end

  assign fifo_push = (state == S_ISSUE) && (cnt == 9'd0);

  fft_tag_fifo #(.DEPTH(TAG_DEPTH), .W(3)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({cur_g, fft_np}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Results are owned by the FIFO head; sop_out restarts the count.
  assign out_take = fft_valid_out && !fifo_empty;
  assign out_idx  = fft_sop_out ? 9'd0 : out_cnt;
  assign out_last = ({1'b0, out_idx} == np_len(fifo_dout[1:0]) - 10'd1);
  assign fifo_pop = out_take && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_sop <= 1'b0; m_eop <= 1'b0; m_tag <= 1'b0;
      m_re <= '0; m_im <= '0; out_cnt <= '0; sop_err <= 1'b0;
    end else begin
      m_valid <= out_take;
      m_sop   <= out_take && fft_sop_out;
      m_eop   <= fifo_pop;
      m_tag   <= out_take ? fifo_dout[2] : 1'b0;
      m_re    <= out_take ? fft_y_re : '0;
      m_im    <= out_take ? fft_y_im : '0;
      if (out_take) out_cnt <= out_last ? 9'd0 : out_idx + 1'b1;
      if (fft_valid_out && fft_sop_out && fifo_empty) sop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: ramp requesters, 10-cycle echo core model,
// table of single-frame arbitration vectors plus multi-cycle corner sequences.
module tb_fft_frame_sched;
  import fft_sched_pkg::*;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [3:0] req_np = '0;
  logic [1:0] req_inv = '0;
  logic [1:0] gnt, s_ready;
  logic v0 = 1'b1, v1 = 1'b1;
  logic [DW-1:0] re0 = '0, re1 = '0, im0 = '0, im1 = '0;
  logic fft_valid_in, fft_sop_in, fft_inv;
  logic [DW-1:0] fft_x_re, fft_x_im;
  logic [1:0] fft_np;
  logic fft_valid_out, fft_sop_out;
  logic [DW-1:0] fft_y_re, fft_y_im;
  logic m_valid, m_sop, m_eop, m_tag, busy, underflow_err, sop_err;
  logic [DW-1:0] m_re, m_im;
  logic [1:0] dbg_state;

  // core model and manual injection sources
  logic echo_en = 1'b1;
  logic core_v = 1'b0, core_sop = 1'b0, man_v = 1'b0, man_sop = 1'b0;
  logic [DW-1:0] core_re = '0, core_im = '0, man_re = '0;
  logic [2*DW+1:0] pipe [10];

  assign fft_valid_out = echo_en ? core_v   : man_v;
  assign fft_sop_out   = echo_en ? core_sop : man_sop;
  assign fft_y_re      = echo_en ? core_re  : man_re;
  assign fft_y_im      = echo_en ? core_im  : '0;

  fft_frame_sched #(.DW(DW), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_np(req_np), .req_inv(req_inv),
    .gnt(gnt), .s_valid({v1, v0}), .s_ready(s_ready),
    .s_re({re1, re0}), .s_im({im1, im0}),
    .fft_valid_in(fft_valid_in), .fft_sop_in(fft_sop_in),
    .fft_x_re(fft_x_re), .fft_x_im(fft_x_im), .fft_np(fft_np), .fft_inv(fft_inv),
    .fft_valid_out(fft_valid_out), .fft_sop_out(fft_sop_out),
    .fft_y_re(fft_y_re), .fft_y_im(fft_y_im),
    .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_tag(m_tag),
    .m_re(m_re), .m_im(m_im), .busy(busy),
    .underflow_err(underflow_err), .sop_err(sop_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    req = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // requester drivers: ramp sample index per granted frame
  int idx0 = 0, idx1 = 0, drop_at = -1;
  initial forever begin
    @(negedge clk);
    if (s_ready[0]) begin
      re0 = idx0[DW-1:0]; im0 = idx0[DW-1:0] + 16'h100; v0 = (idx0 != drop_at); idx0++;
    end else begin
      idx0 = 0; v0 = 1'b1;
    end
    if (s_ready[1]) begin
      re1 = idx1[DW-1:0]; im1 = idx1[DW-1:0] + 16'h200; v1 = 1'b1; idx1++;
    end else begin
      idx1 = 0; v1 = 1'b1;
    end
  end

  // echo core: returns its input 10 samples later, cleared by reset
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) pipe[i] = '0;
    end else begin
      for (int i = 9; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = {fft_valid_in, fft_sop_in, fft_x_re, fft_x_im};
    end
    core_v   = pipe[9][2*DW+1];
    core_sop = pipe[9][2*DW];
    core_re  = pipe[9][2*DW-1:DW];
    core_im  = pipe[9][DW-1:0];
  end

  // monitor + scoreboard of expected tags at each m_eop
  logic [0:0] exp_q[$];
  logic [DW-1:0] vin_re [512];
  int vin_cnt, vin_rise, vsop, gnt_cyc, mv_cnt, msop, meop, data_err, ridx;
  logic prev_vin = 1'b0;

  task automatic clear_counts();
    vin_cnt = 0; vin_rise = 0; vsop = 0; gnt_cyc = 0;
    mv_cnt = 0; msop = 0; meop = 0; data_err = 0; ridx = 0;
  endtask

  initial forever begin
    logic [0:0] e;
    @(negedge clk);
    if (fft_valid_in) begin
      if (!prev_vin) vin_rise++;
      if (vin_cnt < 512) vin_re[vin_cnt] = fft_x_re;
      if (fft_sop_in) vsop++;
      vin_cnt++;
    end
    prev_vin = fft_valid_in;
    if (gnt != 2'b00) gnt_cyc++;
    if (m_valid) begin
      mv_cnt++;
      if (m_sop) begin msop++; ridx = 0; end
      if (m_re != ridx[DW-1:0]) data_err++;
      ridx++;
      if (m_eop) begin
        meop++;
        if (exp_q.size() == 0) begin
          check("unexpected_eop", 32'(m_tag), 32'hdead);
        end else begin
          e = exp_q.pop_front();
          check("eop_tag", 32'(m_tag), 32'(e));
        end
      end
    end
  end

  task automatic wait_gnt(input logic [1:0] g, input int limit, input string name);
    int n = 0;
    while (gnt != g && n < limit) begin @(negedge clk); n++; end
    check(name, 32'(gnt), 32'(g));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || m_valid) && n < 3000) begin @(negedge clk); n++; end
    check(name, 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic inject_frame(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      man_v = 1'b1; man_sop = (i == 0); man_re = i[DW-1:0];
    end
    @(negedge clk);
    man_v = 1'b0; man_sop = 1'b0;
  endtask

  function automatic int ramp_bad(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (vin_re[i] != i[DW-1:0]) bad++;
    return bad;
  endfunction

  typedef struct {
    logic [1:0] req;
    logic [3:0] np;
    logic [1:0] inv;
    logic [1:0] exp_gnt;
    int         exp_n;
    logic [1:0] exp_np;
    logic       exp_inv;
    logic       exp_tag;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    logic bad;
    vecs[0] = '{2'b01, 4'b0000, 2'b00, 2'b01, 64,  2'b00, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 4'b0101, 2'b00, 2'b10, 128, 2'b01, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 4'b1000, 2'b10, 2'b01, 64,  2'b00, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 4'b1100, 2'b10, 2'b10, 512, 2'b11, 1'b1, 1'b1};
    vecs[4] = '{2'b11, 4'b0001, 2'b01, 2'b01, 128, 2'b01, 1'b1, 1'b0};
    clear_counts();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_vin", 32'(fft_valid_in), 0);
    check("rst_mvalid", 32'(m_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_errs", {30'd0, underflow_err, sop_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single-frame vectors with echo core; RR pointer carries across rows
    for (int k = 0; k < 5; k++) begin
      clear_counts();
      req_np = vecs[k].np; req_inv = vecs[k].inv; req = vecs[k].req;
      exp_q.push_back(vecs[k].exp_tag);
      wait_gnt(vecs[k].exp_gnt, 50, $sformatf("v%0d_gnt", k));
      check($sformatf("v%0d_np", k), 32'(fft_np), 32'(vecs[k].exp_np));
      check($sformatf("v%0d_inv", k), 32'(fft_inv), 32'(vecs[k].exp_inv));
      req = 2'b00;
      wait_idle($sformatf("v%0d_idle", k));
      check($sformatf("v%0d_gnt_len", k), gnt_cyc, vecs[k].exp_n);
      check($sformatf("v%0d_vin_cnt", k), vin_cnt, vecs[k].exp_n);
      check($sformatf("v%0d_vin_runs", k), vin_rise, 1);
      check($sformatf("v%0d_sop_in", k), vsop, 1);
      check($sformatf("v%0d_ramp", k), ramp_bad(vecs[k].exp_n), 0);
      check($sformatf("v%0d_m_cnt", k), mv_cnt, vecs[k].exp_n);
      check($sformatf("v%0d_m_sop", k), msop, 1);
      check($sformatf("v%0d_m_eop", k), meop, 1);
      check($sformatf("v%0d_m_data", k), data_err, 0);
    end
    check("no_underflow_yet", 32'(underflow_err), 0);

    // two requesters, stalled core: alternating grants, bubble, full FIFO
    apply_reset();
    echo_en = 1'b0; clear_counts();
    req_np = 4'b0101; req_inv = 2'b00; req = 2'b11;
    wait_gnt(2'b01, 50, "t2_gnt0");
    n = 0;
    while (gnt == 2'b01 && n < 600) begin @(negedge clk); n++; end
    check("t2_len0", n, 128);
    check("t2_bubble", 32'(gnt), 0);
    @(negedge clk);
    check("t2_gnt1", 32'(gnt), 32'(2'b10));
    wait_gnt(2'b01, 300, "t2_gnt2");
    wait_gnt(2'b10, 300, "t2_gnt3");
    n = 0;
    while (gnt != 2'b00 && n < 300) begin @(negedge clk); n++; end
    bad = 1'b0;
    repeat (30) begin @(negedge clk); if (gnt != 2'b00) bad = 1'b1; end
    check("t2_withheld", 32'(bad), 0);
    check("t2_busy_full", 32'(busy), 1);
    exp_q.push_back(1'b0);
    inject_frame(128);
    wait_gnt(2'b01, 20, "t2_gnt4_after_pop");
    req = 2'b00;
    exp_q.push_back(1'b1);
    inject_frame(128);
    repeat (3) @(negedge clk);
    check("t2_m_cnt", mv_cnt, 256);
    check("t2_m_sop", msop, 2);
    check("t2_m_eop", meop, 2);
    check("t2_m_data", data_err, 0);
    apply_reset();

    // np/inv change waits for the in-flight frame to drain
    echo_en = 1'b1; clear_counts();
    req_np = 4'b1100; req_inv = 2'b10; req = 2'b01;
    exp_q.push_back(1'b0);
    wait_gnt(2'b01, 50, "t3_gnt0");
    req = 2'b10;
    exp_q.push_back(1'b1);
    n = 0;
    while (gnt != 2'b00 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    check("t3_state_drain", 32'(dbg_state), 32'(S_DRAIN));
    check("t3_drain_gnt", 32'(gnt), 0);
    bad = 1'b0; n = 0;
    while (!m_eop && n < 200) begin
      if (fft_np != 2'b00 || fft_inv != 1'b0) bad = 1'b1;
      @(negedge clk); n++;
    end
    if (fft_np != 2'b00 || fft_inv != 1'b0) bad = 1'b1;
    check("t3_eop_seen", 32'(m_eop), 1);
    check("t3_np_held", 32'(bad), 0);
    wait_gnt(2'b10, 10, "t3_gnt1");
    check("t3_np_new", 32'(fft_np), 32'(2'b11));
    check("t3_inv_new", 32'(fft_inv), 1);
    req = 2'b00;
    wait_idle("t3_idle");

    // missing sample 10 becomes a zero, frame stays contiguous
    clear_counts();
    req_np = 4'b0000; req_inv = 2'b00; drop_at = 10; req = 2'b01;
    exp_q.push_back(1'b0);
    wait_gnt(2'b01, 50, "t4_gnt");
    req = 2'b00;
    wait_idle("t4_idle");
    drop_at = -1;
    check("t4_vin_cnt", vin_cnt, 64);
    check("t4_vin_runs", vin_rise, 1);
    check("t4_x9", 32'(vin_re[9]), 9);
    check("t4_x10_zero", 32'(vin_re[10]), 0);
    check("t4_x11", 32'(vin_re[11]), 11);
    check("t4_underflow", 32'(underflow_err), 1);

    // stray core output with nothing pending
    check("t5_sop_err_pre", 32'(sop_err), 0);
    echo_en = 1'b0; clear_counts();
    inject_frame(4);
    @(negedge clk);
    check("t5_sop_err", 32'(sop_err), 1);
    check("t5_no_mvalid", mv_cnt, 0);
    check("t5_underflow_sticky", 32'(underflow_err), 1);

    // reset mid-frame aborts; next frame starts clean
    echo_en = 1'b1; clear_counts();
    req = 2'b01;
    wait_gnt(2'b01, 50, "t6_gnt");
    repeat (30) @(negedge clk);
    check("t6_mvalid_before", 32'(m_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", 32'(gnt), 0);
    check("t6_rst_vin", 32'(fft_valid_in), 0);
    check("t6_rst_mvalid", 32'(m_valid), 0);
    check("t6_rst_errs", {30'd0, underflow_err, sop_err}, 0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_counts();
    req = 2'b01;
    exp_q.push_back(1'b0);
    wait_gnt(2'b01, 50, "t6_regnt");
    req = 2'b00;
    wait_idle("t6_idle");
    check("t6_vin_cnt", vin_cnt, 64);
    check("t6_sop_in", vsop, 1);
    check("t6_sop_first", 32'(vin_re[0]), 0);
    check("t6_ramp", ramp_bad(64), 0);
    check("t6_m_cnt", mv_cnt, 64);
    check("t6_m_eop", meop, 1);
    check("t6_m_data", data_err, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
